// File: rtl/bsg_manycore_host_request_arbiter.sv
// Round-robin arbiter with group atomicity feeding a one-entry output register to the host.
// Optional per-requester beat counters enabled by BSG_MANYCORE_HOST_ARB_BEAT_CNT_EN.
module bsg_manycore_host_request_arbiter #(
  parameter int num_req_p      = 2,
  // Coordinate/address widths have no meaningful default; integrations override them.
  parameter int x_cord_width_p = 8,
  parameter int y_cord_width_p = 8,
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  localparam int lg_num_req_lp = $clog2(num_req_p),
  localparam int mask_width_lp = data_width_p >> 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 v_i,
  output logic [num_req_p-1:0]                 yumi_o,
  input  logic [num_req_p-1:0]                 last_i,
  input  logic [num_req_p*data_width_p-1:0]    data_i,
  input  logic [num_req_p*mask_width_lp-1:0]   mask_i,
  input  logic [num_req_p*addr_width_p-1:0]    addr_i,
  input  logic [num_req_p-1:0]                 we_i,
  input  logic [num_req_p*x_cord_width_p-1:0]  src_x_cord_i,
  input  logic [num_req_p*y_cord_width_p-1:0]  src_y_cord_i,
  output logic                                 v_o,
  input  logic                                 rdy_i,
  output logic [data_width_p-1:0]              data_o,
  output logic [mask_width_lp-1:0]             mask_o,
  output logic [addr_width_p-1:0]              addr_o,
  output logic                                 we_o,
  output logic [x_cord_width_p-1:0]            src_x_cord_o,
  output logic [y_cord_width_p-1:0]            src_y_cord_o,
  output logic                                 last_o,
  output logic [lg_num_req_lp-1:0]             grant_id_o,
  output logic [num_req_p*32-1:0]              beat_cnt_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                   state_r, state_n;
  logic [lg_num_req_lp-1:0] ptr_r, ptr_n;
  logic [lg_num_req_lp-1:0] owner_r, owner_n;
  logic                     grant;
  logic [lg_num_req_lp-1:0] sel;
  logic                     scan_found;
  logic [lg_num_req_lp-1:0] scan_idx;
  logic [lg_num_req_lp:0]   scan_k;
  logic                     load;

  function automatic logic [lg_num_req_lp-1:0] wrap_inc(input logic [lg_num_req_lp-1:0] g);
    return (g == lg_num_req_lp'(num_req_p - 1)) ? '0 : g + 1'b1;
  endfunction

  assign load = ~v_o | rdy_i;

  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    owner_n    = owner_r;
    yumi_o     = '0;
    grant      = 1'b0;
    sel        = '0;
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_k     = '0;

    // Priority scan starting at ptr_r, wrapping modulo num_req_p.
    for (int i = 0; i < num_req_p; i++) begin
      scan_k = {1'b0, ptr_r} + (lg_num_req_lp+1)'(i);
      if (scan_k >= (lg_num_req_lp+1)'(num_req_p))
        scan_k = scan_k - (lg_num_req_lp+1)'(num_req_p);
      if (!scan_found && v_i[scan_k[lg_num_req_lp-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = scan_k[lg_num_req_lp-1:0];
      end
    end

    case (state_r)
      IDLE: begin
        if (load && scan_found) begin
          grant = 1'b1;
          sel   = scan_idx;
          if (last_i[scan_idx]) begin
            ptr_n = wrap_inc(scan_idx);
          end else begin
            owner_n = scan_idx;
            state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (load && v_i[owner_r]) begin
          grant = 1'b1;
          sel   = owner_r;
          if (last_i[owner_r]) begin
            ptr_n   = wrap_inc(owner_r);
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (reset_i)
      grant = 1'b0;
    if (grant)
      yumi_o[sel] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      owner_r      <= '0;
      v_o          <= 1'b0;
      data_o       <= '0;
      mask_o       <= '0;
      addr_o       <= '0;
      we_o         <= 1'b0;
      src_x_cord_o <= '0;
      src_y_cord_o <= '0;
      last_o       <= 1'b0;
      grant_id_o   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      // A new grant overwrites a beat draining in the same cycle.
      if (grant) begin
        v_o          <= 1'b1;
        data_o       <= data_i[sel*data_width_p +: data_width_p];
        mask_o       <= mask_i[sel*mask_width_lp +: mask_width_lp];
        addr_o       <= addr_i[sel*addr_width_p +: addr_width_p];
        we_o         <= we_i[sel];
        src_x_cord_o <= src_x_cord_i[sel*x_cord_width_p +: x_cord_width_p];
        src_y_cord_o <= src_y_cord_i[sel*y_cord_width_p +: y_cord_width_p];
        last_o       <= last_i[sel];
        grant_id_o   <= sel;
      end else if (rdy_i) begin
        v_o <= 1'b0;
      end
    end
  end

`ifdef BSG_MANYCORE_HOST_ARB_BEAT_CNT_EN
  logic [31:0] cnt_r [num_req_p];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (reset_i)
        cnt_r[i] <= '0;
      else if (yumi_o[i])
        cnt_r[i] <= cnt_r[i] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_cnt
    assign beat_cnt_o[gi*32 +: 32] = cnt_r[gi];
  end
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_host_request_arbiter.sv
// Self-checking bench for bsg_manycore_host_request_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_bsg_manycore_host_request_arbiter;
  localparam int N  = 2;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = DW >> 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    v_i, last_i, we_i, yumi_o;
  logic [N*DW-1:0] data_i;
  logic [N*MW-1:0] mask_i;
  logic [N*AW-1:0] addr_i;
  logic [N*XW-1:0] x_i;
  logic [N*YW-1:0] y_i;
  logic            v_o, rdy_i, we_o, last_o;
  logic [DW-1:0]   data_o;
  logic [MW-1:0]   mask_o;
  logic [AW-1:0]   addr_o;
  logic [XW-1:0]   x_o;
  logic [YW-1:0]   y_o;
  logic [0:0]      grant_id_o;
  logic [N*32-1:0] beat_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_manycore_host_request_arbiter #(
    .num_req_p(N), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .addr_width_p(AW), .data_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .v_i(v_i), .yumi_o(yumi_o), .last_i(last_i),
    .data_i(data_i), .mask_i(mask_i), .addr_i(addr_i), .we_i(we_i),
    .src_x_cord_i(x_i), .src_y_cord_i(y_i), .v_o(v_o), .rdy_i(rdy_i),
    .data_o(data_o), .mask_o(mask_o), .addr_o(addr_o), .we_o(we_o),
    .src_x_cord_o(x_o), .src_y_cord_o(y_o), .last_o(last_o),
    .grant_id_o(grant_id_o), .beat_cnt_o(beat_cnt_o)
  );

  // Reference model: pointer, owning requester (-1 = no group open), buffered beat, counters.
  int          m_ptr, m_owner, m_gid;
  bit          m_v, m_we, m_last;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  logic [AW-1:0] m_addr;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [31:0]   m_cnt [N];
  logic [N-1:0]  exp_yumi;

  function automatic void model_comb();
    exp_yumi = '0;
    if (reset) return;
    if (!m_v || rdy_i) begin
      if (m_owner >= 0) begin
        if (v_i[m_owner]) exp_yumi[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx = (m_ptr + k) % N;
          if (v_i[idx]) begin
            exp_yumi[idx] = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_clk();
    int g = -1;
    model_comb();
    if (reset) begin
      m_ptr = 0; m_owner = -1; m_gid = 0; m_v = 0; m_we = 0; m_last = 0;
      m_data = '0; m_mask = '0; m_addr = '0; m_x = '0; m_y = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = '0;
      return;
    end
    for (int k = 0; k < N; k++) if (exp_yumi[k]) g = k;
    if (g >= 0) begin
      m_v = 1; m_gid = g;
      m_data = data_i[g*DW +: DW]; m_mask = mask_i[g*MW +: MW];
      m_addr = addr_i[g*AW +: AW]; m_we = we_i[g]; m_last = last_i[g];
      m_x = x_i[g*XW +: XW]; m_y = y_i[g*YW +: YW];
      m_cnt[g] = m_cnt[g] + 32'd1;
      if (last_i[g]) begin
        m_ptr = (g + 1) % N;
        m_owner = -1;
      end else begin
        m_owner = g;
      end
    end else if (rdy_i) begin
      m_v = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v_i = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; v_i = '1; last_i = '1; rdy_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      n_cmp++;
      if (yumi_o !== '0) begin n_err++; $display("FAIL reset_yumi: got %b expected 00", yumi_o); end
      tick();
      n_cmp++;
      if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o: got %b expected 0", v_o); end
    end
    n_cmp++;
    if ({data_o, last_o, grant_id_o, beat_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data %h last %b gid %b cnt %h expected all zero", data_o, last_o, grant_id_o, beat_cnt_o);
    end
    reset = 1'b0;
    #4;
    n_cmp++;
    if (yumi_o !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: got %b expected 01", yumi_o); end
    tick();
    n_cmp++;
    if (grant_id_o !== 1'b0 || v_o !== 1'b1) begin
      n_err++; $display("FAIL reset_first_gid: got gid %b v %b expected gid 0 v 1", grant_id_o, v_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      logic [DW-1:0] exp_d;
      v_i = 2'b11; last_i = 2'b11; rdy_i = 1'b1;
      data_i = {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)};
      exp_d = (n % 2 == 1) ? 32'hB000_0000 + 32'(n) : 32'hA000_0000 + 32'(n);
      #4;
      n_cmp++;
      if (yumi_o !== ((n % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_yumi[%0d]: got %b", n, yumi_o);
      end
      tick();
      n_cmp++;
      if (v_o !== 1'b1 || grant_id_o !== 1'(n % 2) || data_o !== exp_d) begin
        n_err++;
        $display("FAIL rr_beat[%0d]: got v %b gid %0d data %h expected v 1 gid %0d data %h",
                 n, v_o, grant_id_o, data_o, n % 2, exp_d);
      end
    end
  endtask

  task automatic test_group_lock();
    do_reset();
    rdy_i = 1'b1;
    v_i = 2'b01; last_i = 2'b01; data_i = {32'h0, 32'hAAAA_0001};
    tick();
    v_i = 2'b11; last_i = 2'b01; data_i = {32'h1111_2222, 32'hDEAD_0000};
    #4;
    n_cmp++;
    if (yumi_o !== 2'b10) begin n_err++; $display("FAIL lock_first_yumi: got %b expected 10", yumi_o); end
    tick();
    n_cmp++;
    if (data_o !== 32'h1111_2222 || grant_id_o !== 1'b1 || last_o !== 1'b0) begin
      n_err++; $display("FAIL lock_beat0: got data %h gid %b last %b expected 11112222 1 0", data_o, grant_id_o, last_o);
    end
    v_i = 2'b01;
    #4;
    n_cmp++;
    if (yumi_o !== 2'b00) begin n_err++; $display("FAIL lock_gap_yumi: got %b expected 00", yumi_o); end
    tick();
    n_cmp++;
    if (v_o !== 1'b0) begin n_err++; $display("FAIL lock_gap_v: got %b expected 0", v_o); end
    v_i = 2'b11; last_i = 2'b11; data_i = {32'h3333_4444, 32'hDEAD_0000};
    #4;
    n_cmp++;
    if (yumi_o !== 2'b10) begin n_err++; $display("FAIL lock_second_yumi: got %b expected 10", yumi_o); end
    tick();
    n_cmp++;
    if (data_o !== 32'h3333_4444 || grant_id_o !== 1'b1 || last_o !== 1'b1) begin
      n_err++; $display("FAIL lock_beat1: got data %h gid %b last %b expected 33334444 1 1", data_o, grant_id_o, last_o);
    end
    #4;
    n_cmp++;
    if (yumi_o !== 2'b01) begin n_err++; $display("FAIL lock_release_yumi: got %b expected 01", yumi_o); end
    tick();
    n_cmp++;
    if (data_o !== 32'hDEAD_0000 || grant_id_o !== 1'b0) begin
      n_err++; $display("FAIL lock_release_beat: got data %h gid %b expected dead0000 0", data_o, grant_id_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_i = 1'b1; v_i = 2'b01; last_i = 2'b11; data_i = {32'h66, 32'h55};
    tick();
    rdy_i = 1'b0; v_i = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #4;
      n_cmp++;
      if (yumi_o !== 2'b00) begin n_err++; $display("FAIL bp_yumi[%0d]: got %b expected 00", c, yumi_o); end
      tick();
      n_cmp++;
      if (v_o !== 1'b1 || data_o !== 32'h55 || grant_id_o !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v %b data %h gid %b expected 1 55 0", c, v_o, data_o, grant_id_o);
      end
    end
    rdy_i = 1'b1;
    #4;
    n_cmp++;
    if (yumi_o !== 2'b10) begin n_err++; $display("FAIL bp_release_yumi: got %b expected 10", yumi_o); end
    tick();
    n_cmp++;
    if (v_o !== 1'b1 || data_o !== 32'h66 || grant_id_o !== 1'b1) begin
      n_err++; $display("FAIL bp_release_beat: got v %b data %h gid %b expected 1 66 1", v_o, data_o, grant_id_o);
    end
  endtask

  task automatic test_mid_group_reset();
    do_reset();
    rdy_i = 1'b1; v_i = 2'b10; last_i = 2'b00; data_i = {32'h77, 32'h0};
    tick();
    reset = 1'b1; v_i = 2'b00;
    tick();
    n_cmp++;
    if (v_o !== 1'b0) begin n_err++; $display("FAIL mgr_v_o: got %b expected 0", v_o); end
    reset = 1'b0; v_i = 2'b11; last_i = 2'b11;
    #4;
    n_cmp++;
    if (yumi_o !== 2'b01) begin n_err++; $display("FAIL mgr_first_yumi: got %b expected 01", yumi_o); end
    tick();
    n_cmp++;
    if (grant_id_o !== 1'b0) begin n_err++; $display("FAIL mgr_gid: got %b expected 0", grant_id_o); end
  endtask

  task automatic test_beat_counters();
    logic [N*32-1:0] exp_cnt;
    do_reset();
    rdy_i = 1'b1; last_i = 2'b11;
    v_i = 2'b01;
    for (int c = 0; c < 10; c++) tick();
    v_i = 2'b10;
    for (int c = 0; c < 3; c++) tick();
    v_i = 2'b00;
`ifdef BSG_MANYCORE_HOST_ARB_BEAT_CNT_EN
    exp_cnt = {32'd3, 32'd10};
`else
    exp_cnt = '0;
`endif
    n_cmp++;
    if (beat_cnt_o !== exp_cnt) begin
      n_err++; $display("FAIL beat_cnt: got %h expected %h", beat_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [N*32-1:0] exp_cnt;
    reset = 1'b1; v_i = '0;
    @(posedge clk);
    model_clk();
    #1;
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v_i    = N'($urandom);
      last_i = N'($urandom);
      we_i   = N'($urandom);
      rdy_i  = ($urandom_range(3) != 0);
      data_i = {$urandom, $urandom};
      mask_i = (N*MW)'($urandom);
      addr_i = (N*AW)'($urandom);
      x_i    = (N*XW)'($urandom);
      y_i    = (N*YW)'($urandom);
      #4;
      model_comb();
      n_cmp++;
      if (yumi_o !== exp_yumi) begin n_err++; $display("FAIL rand_yumi[%0d]: got %b expected %b", c, yumi_o, exp_yumi); end
      n_cmp++;
      if (v_o !== m_v) begin n_err++; $display("FAIL rand_v_o[%0d]: got %b expected %b", c, v_o, m_v); end
      if (m_v) begin
        n_cmp++;
        if (data_o !== m_data || mask_o !== m_mask || addr_o !== m_addr || we_o !== m_we ||
            x_o !== m_x || y_o !== m_y || last_o !== m_last || grant_id_o !== 1'(m_gid)) begin
          n_err++;
          $display("FAIL rand_beat[%0d]: got d %h m %h a %h we %b x %h y %h l %b g %0d expected d %h m %h a %h we %b x %h y %h l %b g %0d",
                   c, data_o, mask_o, addr_o, we_o, x_o, y_o, last_o, grant_id_o,
                   m_data, m_mask, m_addr, m_we, m_x, m_y, m_last, m_gid);
        end
      end
`ifdef BSG_MANYCORE_HOST_ARB_BEAT_CNT_EN
      for (int k = 0; k < N; k++) exp_cnt[k*32 +: 32] = m_cnt[k];
`else
      exp_cnt = '0;
`endif
      n_cmp++;
      if (beat_cnt_o !== exp_cnt) begin n_err++; $display("FAIL rand_cnt[%0d]: got %h expected %h", c, beat_cnt_o, exp_cnt); end
      @(posedge clk);
      model_clk();
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; v_i = '0; last_i = '0; we_i = '0; rdy_i = 1'b0;
    data_i = '0; mask_i = '0; addr_i = '0; x_i = '0; y_i = '0;
    test_reset();
    test_round_robin();
    test_group_lock();
    test_backpressure();
    test_mid_group_reset();
    test_beat_counters();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
